float_to_int: RTL and testbench

- Downstream stage of floatmul. Consumes its 32-bit IEEE-754 single-precision product z together with the overflow flag.
- Converts the product to a 32-bit two's-complement integer, truncating toward zero, using an iterative one-bit-per-cycle shifter.
- Saturation and invalid status go out alongside the result through a valid/ready handshake toward the integer datapath.

---
 rtl/float_to_int_if.sv | 23 ++
 rtl/float_to_int.sv | 144 ++++++++++++++
 tb/tb_float_to_int.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/float_to_int_if.sv
// Handshake bundle between floatmul and the float-to-integer converter.
// The slave side is the converter; the master side feeds products and drains results.
interface float_to_int_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] z;
  logic [1:0]  ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        sat;
  logic        invalid;

  modport slave (
    input  in_valid, z, ovf, out_ready,
    output in_ready, out_valid, result, sat, invalid
  );

  modport master (
    output in_valid, z, ovf, out_ready,
    input  in_ready, out_valid, result, sat, invalid
  );
endinterface

// File: rtl/float_to_int.sv
// IEEE-754 single-precision to 32-bit signed integer, truncating toward zero.
// The mantissa is aligned by a one-bit-per-cycle shifter, then negated if needed.
module float_to_int #(
  parameter int WIDTH = 32,
  parameter int BIAS  = 127
) (
  input logic          clk,
  input logic          rst,
  float_to_int_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mag;
  logic [4:0]       cnt;
  logic             left;
  logic             sign;
  logic             fixed;
  logic             sat_n;
  logic             inv_n;
  logic [WIDTH-1:0] result_q;
  logic             sat_q;
  logic             inv_q;
  logic             out_valid_q;

  logic [7:0]        e;
  logic [22:0]       frac;
  logic signed [9:0] ex;

  logic [WIDTH-1:0] cap_mag;
  logic [4:0]       cap_cnt;
  logic             cap_left;
  logic             cap_fixed;
  logic             cap_sat;
  logic             cap_inv;

  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] m);
    return neg ? (~m + 1'b1) : m;
  endfunction

  assign e    = bus.z[30:23];
  assign frac = bus.z[22:0];
  assign ex   = $signed({2'b00, e}) - signed'(10'(BIAS));

  // Classify the product at accept time; special cases skip the shifter entirely.
  always_comb begin
    cap_mag   = {{(WIDTH-24){1'b0}}, 1'b1, frac};
    cap_cnt   = 5'd0;
    cap_left  = 1'b0;
    cap_fixed = 1'b1;
    cap_sat   = 1'b0;
    cap_inv   = 1'b0;
    if (bus.ovf == 2'b11 || (e == 8'hFF && frac != 23'd0)) begin
      cap_mag = '0;
      cap_inv = 1'b1;
    end else if (bus.ovf == 2'b01 || e == 8'hFF) begin
      cap_mag = sat_value(bus.z[31]);
      cap_sat = 1'b1;
    end else if (bus.ovf == 2'b10 || e == 8'h00 || ex < 10'sd0) begin
      cap_mag = '0;
    end else if (ex >= 10'sd31) begin
      // -2^31 is representable exactly, so it is not a clamp.
      if (ex == 10'sd31 && bus.z[31] && frac == 23'd0) begin
        cap_mag = sat_value(1'b1);
      end else begin
        cap_mag = sat_value(bus.z[31]);
        cap_sat = 1'b1;
      end
    end else begin
      cap_fixed = 1'b0;
      if (ex >= 10'sd23) begin
        cap_left = 1'b1;
        cap_cnt  = 5'(ex - 10'sd23);
      end else begin
        cap_cnt  = 5'(10'sd23 - ex);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mag         <= '0;
      cnt         <= '0;
      left        <= 1'b0;
      sign        <= 1'b0;
      fixed       <= 1'b0;
      sat_n       <= 1'b0;
      inv_n       <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mag   <= cap_mag;
            cnt   <= cap_cnt;
            left  <= cap_left;
            sign  <= bus.z[31];
            fixed <= cap_fixed;
            sat_n <= cap_sat;
            inv_n <= cap_inv;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != 5'd0) begin
            mag <= left ? (mag << 1) : (mag >> 1);
            cnt <= cnt - 5'd1;
          end else begin
            result_q    <= fixed ? mag : apply_sign(sign, mag);
            sat_q       <= sat_n;
            inv_q       <= inv_n;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.sat       = sat_q;
  assign bus.invalid   = inv_q;

endmodule

// File: tb/tb_float_to_int.sv
// Directed and random checks of float_to_int against an arithmetic reference model.
module tb_float_to_int;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  float_to_int_if bus ();

  float_to_int #(.WIDTH(32), .BIAS(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: value = 1.frac * 2^E computed exactly in 64 bits, then clamped to int32.
  task automatic model(input logic [31:0] zz, input logic [1:0] oo,
                       output logic [31:0] r, output logic s, output logic inv, output int lat);
    int      ee;
    int      ex;
    longint  v;
    logic    sg;
    ee  = int'(zz[30:23]);
    ex  = ee - 127;
    sg  = zz[31];
    r   = 32'd0;
    s   = 1'b0;
    inv = 1'b0;
    lat = 2;
    if (oo == 2'b11 || (ee == 255 && zz[22:0] != 0)) begin
      inv = 1'b1;
    end else if (oo == 2'b01 || ee == 255) begin
      s = 1'b1;
      r = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (oo == 2'b10 || ee == 0 || ex < 0) begin
      r = 32'd0;
    end else if (ex >= 32) begin
      s = 1'b1;
      r = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      v = longint'({1'b1, zz[22:0]});
      if (ex >= 23) v = v * (longint'(1) << (ex - 23));
      else          v = v / (longint'(1) << (23 - ex));
      if (sg) v = -v;
      if (v > 64'sd2147483647) begin
        s = 1'b1; r = 32'h7FFF_FFFF;
      end else if (v < -64'sd2147483648) begin
        s = 1'b1; r = 32'h8000_0000;
      end else begin
        r = v[31:0];
      end
      if (ex < 31) lat = (ex >= 23) ? (ex - 23 + 2) : (23 - ex + 2);
    end
  endtask

  // Called about 1ns after a rising edge with the block idle.
  task automatic convert(input string tag, input logic [31:0] zz, input logic [1:0] oo, input int hold);
    logic [31:0] er;
    logic        es;
    logic        ei;
    int          el;
    int          lat;
    model(zz, oo, er, es, ei, el);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.z        = zz;
    bus.ovf      = oo;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.z        = $urandom;
    bus.ovf      = 2'(($urandom));
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(el));
    chk({tag, ".result"}, bus.result, er);
    chk({tag, ".sat"}, 32'(bus.sat), 32'(es));
    chk({tag, ".invalid"}, 32'(bus.invalid), 32'(ei));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.z        = 32'h3F80_0000;
      bus.ovf      = 2'b00;
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, ".hold_result"}, bus.result, er);
      chk({tag, ".hold_flags"}, {30'd0, bus.sat, bus.invalid}, {30'd0, es, ei});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".drain_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".drain_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".kept_result"}, bus.result, er);
  endtask

  initial begin
    logic [31:0] rz;
    logic [1:0]  ro;
    total = 0;
    bad   = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.z         = 32'd0;
    bus.ovf       = 2'b00;
    #2;
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.result", bus.result, 32'd0);
    chk("reset.flags", {30'd0, bus.sat, bus.invalid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    convert("six", 32'h40C0_0000, 2'b00, 0);
    convert("neg1858", 32'hC4E8_5000, 2'b00, 0);
    convert("three_quarters", 32'h3F40_0000, 2'b00, 0);
    convert("two_pow32", 32'h4F80_0000, 2'b00, 0);
    convert("neg_two_pow31", 32'hCF00_0000, 2'b00, 0);
    convert("ovf_neg", 32'hC000_0000, 2'b01, 0);
    convert("ovf_pos", 32'h4000_0000, 2'b01, 0);
    convert("underflow", 32'h4120_0000, 2'b10, 0);
    convert("nan_flag", 32'h4120_0000, 2'b11, 0);
    convert("nan_code", 32'h7FC0_0000, 2'b00, 0);
    convert("neg_inf", 32'hFF80_0000, 2'b00, 0);
    convert("one", 32'h3F80_0000, 2'b00, 0);
    convert("max_pos", 32'h4EFF_FFFF, 2'b00, 0);
    convert("backpressure", 32'hC2F6_E979, 2'b00, 10);
    convert("after_bp", 32'h4B80_0001, 2'b00, 0);

    // Asynchronous reset part-way through a long conversion.
    bus.z        = 32'h40C0_0000;
    bus.ovf      = 2'b00;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort.result", bus.result, 32'd0);
    chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    convert("six_again", 32'h40C0_0000, 2'b00, 0);

    for (int k = 0; k < 40; k++) begin
      rz = {1'($urandom), 8'($urandom_range(118, 160)), 23'($urandom)};
      ro = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      convert($sformatf("rand%0d", k), rz, ro, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
